// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, result/immediate selects, ALU codes
// and the control bundle carried across the D/E pipeline register.
package rv_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_src_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       adder_src;
      logic [1:0] res_src;
      logic [3:0] alu_control;
      logic [2:0] funct3;
      logic       illegal;
   } de_ctrl_t;

   // alt selects SUB over ADD and SRA over SRL
   function automatic logic [3:0] alu_dec(input logic [2:0] funct3, input logic alt);
      logic [3:0] code;
      case (funct3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/control_unit.sv
// Main decoder: opcode/funct fields to control bundle, immediate type and
// source-register use flags.
module control_unit
   import rv_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output de_ctrl_t   ctrl,
   output imm_src_e   imm_src,
   output logic       use_rs1,
   output logic       use_rs2
);

   always_comb begin
      ctrl             = '0;
      ctrl.res_src     = RES_ALU;
      ctrl.alu_control = ALU_ADD;
      ctrl.funct3      = funct3;
      imm_src          = IMM_I;
      use_rs1          = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
      use_rs2          = (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
      case (op)
         OP_LUI: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_b   = 1'b1;
            ctrl.alu_control = ALU_PASSB;
            imm_src          = IMM_U;
         end
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
            imm_src        = IMM_U;
         end
         OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.res_src   = RES_PC4;
            imm_src        = IMM_J;
         end
         OP_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.res_src   = RES_PC4;
            ctrl.adder_src = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.branch      = 1'b1;
            ctrl.alu_control = ALU_SUB;
            imm_src          = IMM_B;
         end
         OP_LOAD: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.res_src   = RES_LOAD;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src_b = 1'b1;
            imm_src        = IMM_S;
         end
         OP_IMM: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_b   = 1'b1;
            // addi has no subtract form, only srai uses bit 30
            ctrl.alu_control = alu_dec(funct3, funct7b5 && (funct3 == 3'b101));
         end
         OP_OP: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_control = alu_dec(funct3, funct7b5);
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Load-use hazard detection and bubble selection for the D/E register.
// Flush wins over a hazard and never stalls fetch.
module hazard_unit
   import rv_pkg::*;
(
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       use_rs1,
   input  logic       use_rs2,
   input  logic [4:0] rd_e,
   input  logic [1:0] res_src_e,
   input  logic       valid_e,
   input  logic       valid_f,
   input  logic       flush_d,
   output logic       stall_f,
   output logic       bubble
);

   logic load_in_e;
   logic hazard;

   always_comb begin
      load_in_e = valid_e && (res_src_e == RES_LOAD) && (rd_e != 5'd0);
      hazard    = valid_f && load_in_e &&
                  ((use_rs1 && rs1 == rd_e) || (use_rs2 && rs2 == rd_e));
      stall_f   = hazard && !flush_d;
      bubble    = flush_d || !valid_f || hazard;
   end

endmodule

// File: rtl/imm_ext.sv
// Immediate extraction and sign extension for I/S/B/J/U formats.
module imm_ext
   import rv_pkg::*;
(
   input  logic [31:7] instr,
   input  imm_src_e    imm_src,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (imm_src)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'd0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/reg_file.sv
// Architectural register file, two read ports and one write port, with
// optional same-cycle writeback bypass. x0 and out-of-range indices read 0.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter bit BYPASS_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [4:0]            wa,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic [4:0]            ra1,
   input  logic [4:0]            ra2,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2
);

   localparam int RW = $clog2(REG_COUNT);

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic                  wr_ok;

   function automatic logic in_range(input logic [4:0] idx);
      return ({27'd0, idx} < 32'(REG_COUNT));
   endfunction

   assign wr_ok = we && (wa != 5'd0) && in_range(wa);

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) regs_d[wa[RW-1:0]] = wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != 5'd0 && in_range(ra1)) rd1 = regs_q[ra1[RW-1:0]];
      if (ra2 != 5'd0 && in_range(ra2)) rd2 = regs_q[ra2[RW-1:0]];
      if (BYPASS_EN && wr_ok && wa == ra1) rd1 = wd;
      if (BYPASS_EN && wr_ok && wa == ra2) rd2 = wd;
   end

endmodule

// File: rtl/decode_stage_pl.sv
// RV32 decode stage with internal D/E register, load-use stall, flush,
// writeback bypass and illegal-instruction flagging.
module decode_stage_pl
   import rv_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int REG_COUNT     = 32,
   parameter bit BYPASS_EN     = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_f,
   input  logic [DATA_WIDTH-1:0]    instr_f,
   input  logic [ADDRESS_WIDTH-1:0] pc_f,
   input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
   input  logic                     reg_write_w,
   input  logic [4:0]               rd_w,
   input  logic [DATA_WIDTH-1:0]    result_w,
   input  logic                     flush_d,
   output logic                     stall_f,
   output logic                     valid_e,
   output logic                     reg_write_e,
   output logic                     mem_write_e,
   output logic                     jump_e,
   output logic                     branch_e,
   output logic                     alu_src_a_e,
   output logic                     alu_src_b_e,
   output logic                     adder_src_e,
   output logic [1:0]               res_src_e,
   output logic [3:0]               alu_control_e,
   output logic [2:0]               funct3_e,
   output logic [DATA_WIDTH-1:0]    rd1_e,
   output logic [DATA_WIDTH-1:0]    rd2_e,
   output logic [DATA_WIDTH-1:0]    imm_val_e,
   output logic [ADDRESS_WIDTH-1:0] pc_e,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
   output logic [4:0]               rs1_e,
   output logic [4:0]               rs2_e,
   output logic [4:0]               rd_e,
   output logic                     illegal_e,
   output logic [31:0]              stall_count
);

   logic [4:0]            rs1_f;
   logic [4:0]            rs2_f;
   logic [4:0]            rd_f;
   de_ctrl_t              ctrl_dec;
   de_ctrl_t              ctrl_ok;
   imm_src_e              imm_src;
   logic                  use_rs1;
   logic                  use_rs2;
   logic [31:0]           imm32;
   logic [DATA_WIDTH-1:0] rd1_f;
   logic [DATA_WIDTH-1:0] rd2_f;
   logic                  bubble;
   logic                  illegal_d;

   de_ctrl_t                 ctrl_d,        ctrl_q;
   logic                     valid_d,       valid_q;
   logic [DATA_WIDTH-1:0]    rd1_d,         rd1_q;
   logic [DATA_WIDTH-1:0]    rd2_d,         rd2_q;
   logic [DATA_WIDTH-1:0]    imm_d,         imm_q;
   logic [ADDRESS_WIDTH-1:0] pc_d,          pc_q;
   logic [ADDRESS_WIDTH-1:0] pc4_d,         pc4_q;
   logic [4:0]               rs1_d,         rs1_q;
   logic [4:0]               rs2_d,         rs2_q;
   logic [4:0]               rd_d,          rd_q;
   logic [31:0]              stall_count_d, stall_count_q;

   assign rs1_f = instr_f[19:15];
   assign rs2_f = instr_f[24:20];
   assign rd_f  = instr_f[11:7];

   function automatic logic idx_oob(input logic [4:0] idx);
      return ({27'd0, idx} >= 32'(REG_COUNT));
   endfunction

   control_unit u_ctrl (
      .op       (instr_f[6:0]),
      .funct3   (instr_f[14:12]),
      .funct7b5 (instr_f[30]),
      .ctrl     (ctrl_dec),
      .imm_src  (imm_src),
      .use_rs1  (use_rs1),
      .use_rs2  (use_rs2)
   );

   imm_ext u_imm (
      .instr   (instr_f[31:7]),
      .imm_src (imm_src),
      .imm     (imm32)
   );

   reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT),
      .BYPASS_EN  (BYPASS_EN)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (reg_write_w),
      .wa    (rd_w),
      .wd    (result_w),
      .ra1   (rs1_f),
      .ra2   (rs2_f),
      .rd1   (rd1_f),
      .rd2   (rd2_f)
   );

   hazard_unit u_haz (
      .rs1       (rs1_f),
      .rs2       (rs2_f),
      .use_rs1   (use_rs1),
      .use_rs2   (use_rs2),
      .rd_e      (rd_q),
      .res_src_e (ctrl_q.res_src),
      .valid_e   (valid_q),
      .valid_f   (valid_f),
      .flush_d   (flush_d),
      .stall_f   (stall_f),
      .bubble    (bubble)
   );

   // Illegal instructions still travel as valid so the trap is seen in E,
   // but they must never write architectural state.
   always_comb begin
      illegal_d = ctrl_dec.illegal ||
                  (use_rs1 && idx_oob(rs1_f)) ||
                  (use_rs2 && idx_oob(rs2_f)) ||
                  (ctrl_dec.reg_write && idx_oob(rd_f));
      ctrl_ok         = ctrl_dec;
      ctrl_ok.illegal = illegal_d;
      if (illegal_d) begin
         ctrl_ok.reg_write = 1'b0;
         ctrl_ok.mem_write = 1'b0;
      end
   end

   always_comb begin
      valid_d       = valid_q;
      ctrl_d        = ctrl_q;
      rd1_d         = rd1_q;
      rd2_d         = rd2_q;
      imm_d         = imm_q;
      pc_d          = pc_q;
      pc4_d         = pc4_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      rd_d          = rd_q;
      stall_count_d = stall_count_q;
      if (bubble) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_ok;
         rd1_d   = rd1_f;
         rd2_d   = rd2_f;
         imm_d   = DATA_WIDTH'($signed(imm32));
         pc_d    = pc_f;
         pc4_d   = pc_plus4_f;
         rs1_d   = rs1_f;
         rs2_d   = rs2_f;
         rd_d    = rd_f;
      end
      if (stall_f && stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         ctrl_q        <= '0;
         rd1_q         <= '0;
         rd2_q         <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         pc4_q         <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         stall_count_q <= '0;
      end else begin
         valid_q       <= valid_d;
         ctrl_q        <= ctrl_d;
         rd1_q         <= rd1_d;
         rd2_q         <= rd2_d;
         imm_q         <= imm_d;
         pc_q          <= pc_d;
         pc4_q         <= pc4_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rd_q          <= rd_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign valid_e       = valid_q;
   assign reg_write_e   = ctrl_q.reg_write;
   assign mem_write_e   = ctrl_q.mem_write;
   assign jump_e        = ctrl_q.jump;
   assign branch_e      = ctrl_q.branch;
   assign alu_src_a_e   = ctrl_q.alu_src_a;
   assign alu_src_b_e   = ctrl_q.alu_src_b;
   assign adder_src_e   = ctrl_q.adder_src;
   assign res_src_e     = ctrl_q.res_src;
   assign alu_control_e = ctrl_q.alu_control;
   assign funct3_e      = ctrl_q.funct3;
   assign illegal_e     = ctrl_q.illegal;
   assign rd1_e         = rd1_q;
   assign rd2_e         = rd2_q;
   assign imm_val_e     = imm_q;
   assign pc_e          = pc_q;
   assign pc_plus4_e    = pc4_q;
   assign rs1_e         = rs1_q;
   assign rs2_e         = rs2_q;
   assign rd_e          = rd_q;
   assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_decode_stage_pl.sv
// Directed bench for decode_stage_pl configured as RV32E (16 registers).
module tb_decode_stage_pl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_f;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic [31:0] pc_plus4_f;
   logic        reg_write_w;
   logic [4:0]  rd_w;
   logic [31:0] result_w;
   logic        flush_d;
   logic        stall_f;
   logic        valid_e;
   logic        reg_write_e, mem_write_e, jump_e, branch_e;
   logic        alu_src_a_e, alu_src_b_e, adder_src_e;
   logic [1:0]  res_src_e;
   logic [3:0]  alu_control_e;
   logic [2:0]  funct3_e;
   logic [31:0] rd1_e, rd2_e, imm_val_e;
   logic [31:0] pc_e, pc_plus4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic        illegal_e;
   logic [31:0] stall_count;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] I_LW_X5_X1   = 32'h0000A283;
   localparam logic [31:0] I_ADD_6_5_2  = 32'h00228333;
   localparam logic [31:0] I_ADDI_4_3_1 = 32'h00118213;
   localparam logic [31:0] I_ADDI_4_0_5 = 32'h00500213;
   localparam logic [31:0] I_ADDI_4_7_0 = 32'h00038213;
   localparam logic [31:0] I_ADDI_4_5_0 = 32'h00028213;
   localparam logic [31:0] I_ADD_17_1_2 = 32'h002088B3;
   localparam logic [31:0] I_FENCE      = 32'h0000000F;

   decode_stage_pl #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .REG_COUNT     (16),
      .BYPASS_EN     (1'b1)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_f       (valid_f),
      .instr_f       (instr_f),
      .pc_f          (pc_f),
      .pc_plus4_f    (pc_plus4_f),
      .reg_write_w   (reg_write_w),
      .rd_w          (rd_w),
      .result_w      (result_w),
      .flush_d       (flush_d),
      .stall_f       (stall_f),
      .valid_e       (valid_e),
      .reg_write_e   (reg_write_e),
      .mem_write_e   (mem_write_e),
      .jump_e        (jump_e),
      .branch_e      (branch_e),
      .alu_src_a_e   (alu_src_a_e),
      .alu_src_b_e   (alu_src_b_e),
      .adder_src_e   (adder_src_e),
      .res_src_e     (res_src_e),
      .alu_control_e (alu_control_e),
      .funct3_e      (funct3_e),
      .rd1_e         (rd1_e),
      .rd2_e         (rd2_e),
      .imm_val_e     (imm_val_e),
      .pc_e          (pc_e),
      .pc_plus4_e    (pc_plus4_e),
      .rs1_e         (rs1_e),
      .rs2_e         (rs2_e),
      .rd_e          (rd_e),
      .illegal_e     (illegal_e),
      .stall_count   (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      valid_f    = 1'b1;
      instr_f    = instr;
      pc_f       = pc;
      pc_plus4_f = pc + 32'd4;
   endtask

   task automatic load_use(input string tag);
      present(I_LW_X5_X1, 32'h200);
      tick();
      present(I_ADD_6_5_2, 32'h204);
      #1;
      check({tag, "_stall"}, {31'd0, stall_f}, 32'd1);
      tick();
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      valid_f     = 1'b0;
      instr_f     = '0;
      pc_f        = '0;
      pc_plus4_f  = '0;
      reg_write_w = 1'b0;
      rd_w        = '0;
      result_w    = '0;
      flush_d     = 1'b0;
      tick();
      tick();
      check("rst_valid_e", {31'd0, valid_e}, 32'd0);
      check("rst_stall_count", stall_count, 32'd0);
      check("rst_stall_f", {31'd0, stall_f}, 32'd0);
      rst_n = 1'b1;

      // preload x1, x2, x5 with no instruction in D
      reg_write_w = 1'b1;
      rd_w = 5'd1; result_w = 32'h0000_0100; tick();
      rd_w = 5'd2; result_w = 32'h0000_0022; tick();
      rd_w = 5'd5; result_w = 32'h0000_0055; tick();
      reg_write_w = 1'b0;
      check("novalid_bubble", {31'd0, valid_e}, 32'd0);

      // load-use: lw x5,0(x1) then add x6,x5,x2
      present(I_LW_X5_X1, 32'h100);
      #1;
      check("lw_no_stall", {31'd0, stall_f}, 32'd0);
      tick();
      check("lw_valid_e", {31'd0, valid_e}, 32'd1);
      check("lw_res_src", {30'd0, res_src_e}, 32'd1);
      check("lw_rd_e", {27'd0, rd_e}, 32'd5);
      check("lw_rd1", rd1_e, 32'h100);
      check("lw_pc", pc_e, 32'h100);
      check("lw_pc4", pc_plus4_e, 32'h104);
      check("lw_ctrl", {25'd0, reg_write_e, alu_src_b_e, mem_write_e, jump_e, branch_e,
                        alu_src_a_e, adder_src_e}, 32'b1100000);
      check("lw_funct3", {29'd0, funct3_e}, 32'd2);
      present(I_ADD_6_5_2, 32'h104);
      #1;
      check("lu_stall_f", {31'd0, stall_f}, 32'd1);
      tick();
      check("lu_bubble_valid", {31'd0, valid_e}, 32'd0);
      check("lu_bubble_regw", {31'd0, reg_write_e}, 32'd0);
      check("lu_count", stall_count, 32'd1);
      check("lu_release", {31'd0, stall_f}, 32'd0);
      tick();
      check("add_valid", {31'd0, valid_e}, 32'd1);
      check("add_rs1_e", {27'd0, rs1_e}, 32'd5);
      check("add_rs2_e", {27'd0, rs2_e}, 32'd2);
      check("add_rd1", rd1_e, 32'h55);
      check("add_rd2", rd2_e, 32'h22);
      check("add_alu", {28'd0, alu_control_e}, 32'd0);
      check("add_count", stall_count, 32'd1);

      // writeback bypass
      present(I_ADDI_4_3_1, 32'h108);
      reg_write_w = 1'b1; rd_w = 5'd3; result_w = 32'hDEAD_BEEF;
      tick();
      check("byp_rd1", rd1_e, 32'hDEAD_BEEF);
      check("byp_imm", imm_val_e, 32'd1);
      present(I_ADDI_4_0_5, 32'h10C);
      rd_w = 5'd0; result_w = 32'h1234_5678;
      tick();
      check("x0_rd1", rd1_e, 32'd0);
      check("x0_imm", imm_val_e, 32'd5);
      reg_write_w = 1'b0;

      // flush priority over hazard, writeback still commits
      present(I_LW_X5_X1, 32'h110);
      tick();
      present(I_ADD_6_5_2, 32'h114);
      flush_d = 1'b1;
      reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'h77;
      #1;
      check("flush_stall_f", {31'd0, stall_f}, 32'd0);
      tick();
      flush_d = 1'b0;
      reg_write_w = 1'b0;
      check("flush_valid_e", {31'd0, valid_e}, 32'd0);
      check("flush_count", stall_count, 32'd1);
      present(I_ADDI_4_7_0, 32'h118);
      tick();
      check("flush_wb_x7", rd1_e, 32'h77);

      // RV32E index and opcode legality
      present(I_ADD_17_1_2, 32'h11C);
      tick();
      check("ill_rd_flag", {31'd0, illegal_e}, 32'd1);
      check("ill_rd_regw", {31'd0, reg_write_e}, 32'd0);
      check("ill_rd_valid", {31'd0, valid_e}, 32'd1);
      present(I_FENCE, 32'h120);
      tick();
      check("ill_op_flag", {31'd0, illegal_e}, 32'd1);
      check("ill_op_valid", {31'd0, valid_e}, 32'd1);
      present(I_ADDI_4_3_1, 32'h124);
      tick();
      check("legal_flag", {31'd0, illegal_e}, 32'd0);

      // saturation
      force u_dut.stall_count_q = 32'hFFFF_FFFE;
      #1;
      release u_dut.stall_count_q;
      load_use("sat1");
      check("sat_reach", stall_count, 32'hFFFF_FFFF);
      load_use("sat2");
      check("sat_hold", stall_count, 32'hFFFF_FFFF);

      // asynchronous reset in the middle of a stall
      present(I_LW_X5_X1, 32'h300);
      tick();
      present(I_ADD_6_5_2, 32'h304);
      #1;
      check("pre_rst_stall", {31'd0, stall_f}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_stall_f", {31'd0, stall_f}, 32'd0);
      check("arst_valid_e", {31'd0, valid_e}, 32'd0);
      check("arst_rd1", rd1_e, 32'd0);
      check("arst_count", stall_count, 32'd0);
      valid_f = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      present(I_ADDI_4_5_0, 32'h308);
      tick();
      check("post_rst_valid", {31'd0, valid_e}, 32'd1);
      check("post_rst_x5", rd1_e, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
